// File: rtl/corelet_pkg.sv
// corelet_pkg: shared inst-word bit layout, idle word and sequencer state encoding
package corelet_pkg;
    localparam int INST_W = 35;
    localparam int ADDR_W = 11;
    localparam int ACC = 33;
    localparam int CEN_PMEM = 32;
    localparam int WEN_PMEM = 31;
    localparam int A_PMEM = 20;
    localparam int CEN_XMEM = 19;
    localparam int WEN_XMEM = 18;
    localparam int A_XMEM = 7;
    localparam int OFIFO_RD = 6;
    localparam int IFIFO_WR = 5;
    localparam int IFIFO_RD = 4;
    localparam int L0_RD = 3;
    localparam int L0_WR = 2;
    localparam int EXECUTE = 1;
    localparam int LOAD = 0;
    localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;
    typedef enum logic [2:0] {S_IDLE, S_WLD, S_KLD, S_KFL, S_ALD, S_EXE, S_DRN, S_FIN} state_t;
endpackage

// File: rtl/corelet_seq_if.sv
// corelet_seq_if: host start/config handshake plus corelet status and instruction word
interface corelet_seq_if;
    import corelet_pkg::*;
    logic              start;
    logic [3:0]        cfg_nkij;
    logic [6:0]        cfg_nact;
    logic              l0_full;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy;
    logic              done;
    logic              err_ovf;
    modport master (
        input  start, cfg_nkij, cfg_nact, l0_full, ofifo_valid,
        output inst, busy, done, err_ovf
    );
    modport slave (
        output start, cfg_nkij, cfg_nact, l0_full, ofifo_valid,
        input  inst, busy, done, err_ovf
    );
endinterface

// File: rtl/seq_mem_rd.sv
// seq_mem_rd: streams n xmem reads from base, stalling on l0_full, with the L0 write one cycle behind each read
module seq_mem_rd
    import corelet_pkg::*;
#(
    parameter int CW = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [ADDR_W-1:0] base,
    input  logic [CW-1:0]     n,
    input  logic              l0_full,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic              last
);
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] wr_cnt;
    logic          pend;

    // a read goes out while reads remain and L0 has room; its write lands on the next cycle regardless
    always_comb begin
        rd = en && rd_cnt < n && !l0_full;
        addr = base + ADDR_W'(rd_cnt);
        wr = en && pend;
        last = wr && wr_cnt == n - 1'b1;
    end

    // counters restart whenever the owning phase is inactive
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            pend <= 1'b0;
        end else if (!en) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            pend <= 1'b0;
        end else begin
            rd_cnt <= rd_cnt + CW'(rd);
            wr_cnt <= wr_cnt + CW'(wr);
            pend <= rd;
        end
    end
endmodule

// File: rtl/corelet_seq.sv
// corelet_seq: per-kij weight load, kernel shift, activation load, execute and OFIFO drain into pmem
module corelet_seq
    import corelet_pkg::*;
#(
    parameter int                row     = 8,
    parameter int                col     = 8,
    parameter logic [ADDR_W-1:0] W_BASE  = 11'd0,
    parameter logic [ADDR_W-1:0] A_BASE  = 11'd64,
    parameter logic [ADDR_W-1:0] P_BASE  = 11'd0,
    parameter int                ACT_MAX = 64
) (
    input logic           clk,
    input logic           reset,
    corelet_seq_if.master bus
);
    localparam int CW = $clog2(ACT_MAX) + 1;

    state_t            state;
    state_t            nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     nact;
    logic [CW-1:0]     drd;
    logic [CW-1:0]     dwr;
    logic              dpend;
    logic [3:0]        kij;
    logic [3:0]        nkij;
    logic              accept;
    logic              ofifo_rd;
    logic              mr_en;
    logic              mr_rd;
    logic              mr_wr;
    logic              mr_last;
    logic [ADDR_W-1:0] mr_base;
    logic [ADDR_W-1:0] mr_addr;
    logic [CW-1:0]     mr_n;
    logic [INST_W-1:0] inst_d;

    // shared read streamer: weights in WLD, activations in ALD
    always_comb begin
        accept = state == S_IDLE && bus.start && !bus.busy;
        mr_en = state == S_WLD || state == S_ALD;
        mr_base = state == S_WLD ? W_BASE + ADDR_W'(kij) * ADDR_W'(col) : A_BASE;
        mr_n = state == S_WLD ? CW'(col) : nact;
        ofifo_rd = state == S_DRN && bus.ofifo_valid && drd < nact;
    end

    seq_mem_rd #(.CW(CW)) u_mem_rd (
        .clk     (clk),
        .reset   (reset),
        .en      (mr_en),
        .base    (mr_base),
        .n       (mr_n),
        .l0_full (bus.l0_full),
        .rd      (mr_rd),
        .addr    (mr_addr),
        .wr      (mr_wr),
        .last    (mr_last)
    );

    // next state and the instruction word to present on the following cycle
    always_comb begin
        nxt = state;
        inst_d = IDLE_INST;
        inst_d[IFIFO_WR] = 1'b0;
        inst_d[IFIFO_RD] = 1'b0;
        case (state)
            S_IDLE: nxt = accept ? S_WLD : S_IDLE;
            S_WLD, S_ALD: begin
                inst_d[CEN_XMEM] = !mr_rd;
                inst_d[WEN_XMEM] = 1'b1;
                inst_d[A_XMEM +: ADDR_W] = mr_rd ? mr_addr : '0;
                inst_d[L0_WR] = mr_wr;
                if (mr_last) nxt = state == S_WLD ? S_KLD : S_EXE;
            end
            S_KLD: begin
                inst_d[L0_RD] = 1'b1;
                inst_d[LOAD] = 1'b1;
                if (cnt == CW'(col - 1)) nxt = S_KFL;
            end
            S_KFL: if (cnt == CW'(row + col - 1)) nxt = S_ALD;
            S_EXE: begin
                inst_d[L0_RD] = 1'b1;
                inst_d[EXECUTE] = 1'b1;
                if (cnt == nact - 1'b1) nxt = S_DRN;
            end
            S_DRN: begin
                inst_d[OFIFO_RD] = ofifo_rd;
                inst_d[CEN_PMEM] = !dpend;
                inst_d[WEN_PMEM] = !dpend;
                inst_d[A_PMEM +: ADDR_W] = dpend ? P_BASE + ADDR_W'(dwr) : '0;
                inst_d[ACC] = dpend && kij != 4'd0;
                if (dpend && dwr == nact - 1'b1) nxt = kij == nkij - 1'b1 ? S_FIN : S_WLD;
            end
            S_FIN: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else state <= nxt;
    end

    // phase cycle counter, drain counters, latched job config and kij index
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            drd <= '0;
            dwr <= '0;
            dpend <= 1'b0;
            kij <= '0;
            nkij <= 4'd1;
            nact <= CW'(1);
        end else begin
            cnt <= nxt != state ? '0 : cnt + 1'b1;
            drd <= state == S_DRN ? drd + CW'(ofifo_rd) : '0;
            dwr <= state == S_DRN ? dwr + CW'(dpend) : '0;
            dpend <= ofifo_rd;
            if (accept) begin
                kij <= '0;
                nkij <= bus.cfg_nkij == 4'd0 ? 4'd1 : bus.cfg_nkij;
                nact <= bus.cfg_nact == 7'd0 ? CW'(1) : CW'(bus.cfg_nact);
            end else if (state == S_DRN && nxt == S_WLD) begin
                kij <= kij + 1'b1;
            end
        end
    end

    // registered outputs; err_ovf is sticky until the next accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.inst <= IDLE_INST;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err_ovf <= 1'b0;
        end else begin
            bus.inst <= inst_d;
            bus.busy <= state == S_IDLE ? accept : 1'b1;
            bus.done <= state == S_FIN;
            bus.err_ovf <= accept ? 1'b0 : bus.err_ovf | (mr_wr && bus.l0_full);
        end
    end
endmodule
